// File: rtl/sobel_stream_ctrl.sv
// Raster-stream sequencer around a 3x3 Sobel edge test: two line buffers build the
// window, one edge bit leaves per pixel in raster order, border positions are forced to 0.
module sobel_stream_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pixel,
    input  logic [7:0] cfg_threshold,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_result,
    output logic       frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 2);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);
    localparam logic [FW-1:0] FLUSH_LEN = FW'(IMG_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Sobel datapath: 11-bit signed differences, strict magnitude compare.
    function automatic logic sobel_edge(
        input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
        input logic [7:0] p3, input logic [7:0] p5, input logic [7:0] p6,
        input logic [7:0] p7, input logic [7:0] p8, input logic [7:0] thr
    );
        logic signed [10:0] d1;
        logic signed [10:0] d2;
        logic        [10:0] a1;
        logic        [10:0] a2;
        d1 = $signed({3'b000, p5}) + $signed({3'b000, p7}) + $signed({3'b000, p8})
           - $signed({3'b000, p0}) - $signed({3'b000, p1}) - $signed({3'b000, p3});
        d2 = $signed({3'b000, p3}) + $signed({3'b000, p6}) + $signed({3'b000, p7})
           - $signed({3'b000, p1}) - $signed({3'b000, p2}) - $signed({3'b000, p5});
        a1 = d1[10] ? $unsigned(-d1) : $unsigned(d1);
        a2 = d2[10] ? $unsigned(-d2) : $unsigned(d2);
        sobel_edge = (a1 > {3'b000, thr}) || (a2 > {3'b000, thr});
    endfunction

    state_t        state_r;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [7:0]    thr_r;
    logic [FW-1:0] flush_cnt_r;
    logic [7:0]    win_r [9];
    logic [7:0]    lb1_r [IMG_WIDTH];
    logic [7:0]    lb2_r [IMG_WIDTH];
    logic          ready_en_r;
    logic          out_valid_r;
    logic          out_result_r;
    logic          frame_done_r;

    logic          out_free_s;
    logic          in_ready_s;
    logic          accept_s;
    logic [7:0]    up_s;
    logic [7:0]    mid_s;
    logic          edge_s;
    logic          border_s;
    logic          last_col_s;
    logic          last_row_s;

    // Handshake qualifiers and the incoming window column seen by the datapath.
    always_comb begin
        out_free_s = !out_valid_r || out_ready;
        case (state_r)
            IDLE:    in_ready_s = ready_en_r && !frame_done_r;
            FILL:    in_ready_s = 1'b1;
            RUN:     in_ready_s = out_free_s;
            FLUSH:   in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
        accept_s   = in_valid && in_ready_s;
        up_s       = lb2_r[col_r];
        mid_s      = lb1_r[col_r];
        last_col_s = (col_r == COL_LAST);
        last_row_s = (row_r == ROW_LAST);
        // The window centre trails the input by one row and one column.
        border_s   = (col_r <= COL_ONE) || (row_r <= ROW_ONE);
        edge_s     = sobel_edge(win_r[1], win_r[2], up_s,
                                win_r[4], mid_s,
                                win_r[7], win_r[8], in_pixel, thr_r);
    end

    // Line buffers: column col holds rows r-1 (lb1) and r-2 (lb2).
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_r[col_r] <= lb1_r[col_r];
            lb1_r[col_r] <= in_pixel;
        end
    end

    // Frame FSM, input counters, window shift and the registered result stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            col_r        <= '0;
            row_r        <= '0;
            thr_r        <= 8'd0;
            flush_cnt_r  <= '0;
            ready_en_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_result_r <= 1'b0;
            frame_done_r <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= 8'd0;
            end
        end else begin
            ready_en_r   <= 1'b1;
            frame_done_r <= 1'b0;
            if (accept_s) begin
                win_r[0] <= win_r[1];
                win_r[1] <= win_r[2];
                win_r[2] <= up_s;
                win_r[3] <= win_r[4];
                win_r[4] <= win_r[5];
                win_r[5] <= mid_s;
                win_r[6] <= win_r[7];
                win_r[7] <= win_r[8];
                win_r[8] <= in_pixel;
                if (last_col_s) begin
                    col_r <= '0;
                    row_r <= last_row_s ? '0 : row_r + 1'b1;
                end else begin
                    col_r <= col_r + 1'b1;
                end
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        thr_r   <= cfg_threshold;
                        state_r <= FILL;
                    end
                end
                FILL: begin
                    if (accept_s && (row_r == ROW_ONE) && (col_r == '0)) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        out_valid_r  <= 1'b1;
                        out_result_r <= edge_s && !border_s;
                        if (last_col_s && last_row_s) begin
                            state_r     <= FLUSH;
                            flush_cnt_r <= '0;
                        end
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                FLUSH: begin
                    // Remaining results all sit on the bottom border.
                    if (out_free_s) begin
                        if (flush_cnt_r != FLUSH_LEN) begin
                            out_valid_r  <= 1'b1;
                            out_result_r <= 1'b0;
                            flush_cnt_r  <= flush_cnt_r + 1'b1;
                        end else begin
                            out_valid_r  <= 1'b0;
                            frame_done_r <= 1'b1;
                            state_r      <= IDLE;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed bench for sobel_stream_ctrl: an 8x6 instance for image/threshold/reset
// scenarios and a 3x3 instance streaming three frames back to back.
module tb_sobel_stream_ctrl;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_result, frame_done;
    logic [7:0] in_pixel, cfg_threshold;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_result, b_frame_done;
    logic [7:0] b_in_pixel, b_cfg_threshold;

    int n_cmp = 0;
    int n_err = 0;

    sobel_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .cfg_threshold(cfg_threshold),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .frame_done(frame_done)
    );

    sobel_stream_ctrl #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel),
        .cfg_threshold(b_cfg_threshold),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
        .frame_done(b_frame_done)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Step image: columns 0-3 = base, columns 4-7 = base+step.
    function automatic logic [7:0] pix8(input int idx, input int base, input int step);
        int c;
        c = idx % W;
        return 8'((c >= 4) ? base + step : base);
    endfunction

    // At interior centres in columns 3 and 4 the window straddles the step and
    // |d1| = |d2| = 2*step; everywhere else both differences are zero.
    function automatic logic exp8(input int k, input int step, input int thr);
        int r;
        int c;
        r = k / W;
        c = k % W;
        return (r >= 1) && (r <= H - 2) && ((c == 3) || (c == 4)) && (2 * step > thr);
    endfunction

    // Frames 0,1: checkerboard; frame 2: only the bottom-right pixel bright.
    function automatic logic [7:0] pix3(input int idx);
        int f;
        int j;
        f = idx / 9;
        j = idx % 9;
        if (f < 2) return (((j / 3) + (j % 3)) % 2 == 1) ? 8'd255 : 8'd0;
        return (j == 8) ? 8'd255 : 8'd0;
    endfunction

    task automatic run_frame(input int base, input int step, input int thr, input int thr_eff,
                             input bit rnd, input int chg_at, input int abort_at);
        int   in_idx = 0;
        int   out_idx = 0;
        int   cyc = 0;
        int   done_cnt = 0;
        int   first_acc = -1;
        int   done_cyc = -1;
        logic acc;
        logic emt;
        logic prev_emit = 1'b0;
        logic prev_hold = 1'b0;
        logic prev_res = 1'b0;
        cfg_threshold = 8'(thr);
        while ((done_cnt == 0) && (cyc < 3000) && (in_idx != abort_at)) begin
            @(negedge clk);
            if (in_idx == chg_at) cfg_threshold = 8'd255;
            in_valid  = (in_idx < N) && (!rnd || ($urandom_range(0, 3) != 0));
            in_pixel  = pix8(in_idx, base, step);
            out_ready = !rnd || ($urandom_range(0, 1) == 1);
            #1;
            if (prev_hold) begin
                check1("hold_valid", out_valid, 1'b1);
                check1("hold_result", out_result, prev_res);
            end
            if (out_valid && !out_ready) check1("ready_blocked", in_ready, 1'b0);
            if (in_idx == N) check1("flush_ready_low", in_ready, 1'b0);
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check1("done_after_emit", prev_emit, 1'b1);
                checkn("done_emit_count", out_idx, N);
            end
            acc = in_valid && in_ready;
            emt = out_valid && out_ready;
            if (acc && (first_acc < 0)) first_acc = cyc;
            if (emt) begin
                check1("emit_in_range", out_idx < N, 1'b1);
                if (out_idx < N)
                    check1($sformatf("res_%0d", out_idx), out_result, exp8(out_idx, step, thr_eff));
                out_idx++;
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = out_result;
            prev_emit = emt;
            if (acc) in_idx++;
            cyc++;
        end
        if (in_idx != abort_at) begin
            checkn("frame_done_count", done_cnt, 1);
            checkn("result_count", out_idx, N);
            if (!rnd) checkn("frame_cycles", done_cyc - first_acc, N + W + 2);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int b_in;
        int b_out;
        int b_done;
        int b_tail;
        int cyc;
        rst_n = 1'b0;
        in_valid = 1'b0; in_pixel = 8'd0; out_ready = 1'b0; cfg_threshold = 8'd0;
        b_in_valid = 1'b0; b_in_pixel = 8'd0; b_out_ready = 1'b1; b_cfg_threshold = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_out_result", out_result, 1'b0);
        check1("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check1("idle_ready", in_ready, 1'b1);

        // Uniform frame, vertical step, step under random back-pressure.
        run_frame(100, 0, 10, 10, 1'b0, -1, -1);
        run_frame(0, 200, 50, 50, 1'b0, -1, -1);
        run_frame(0, 200, 50, 50, 1'b1, -1, -1);

        // Threshold change mid-frame is ignored; next frame latches 255.
        run_frame(0, 60, 50, 50, 1'b0, 11, -1);
        run_frame(0, 60, 255, 255, 1'b0, -1, -1);

        // Reset after 20 accepts, then a clean frame.
        run_frame(0, 200, 50, 50, 1'b0, -1, 20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check1("abort_in_ready", in_ready, 1'b0);
        check1("abort_out_valid", out_valid, 1'b0);
        check1("abort_out_result", out_result, 1'b0);
        check1("abort_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check1("abort_idle_ready", in_ready, 1'b1);
        run_frame(0, 200, 50, 50, 1'b0, -1, -1);

        // 3x3 instance, in_valid held high across three frames.
        b_in = 0; b_out = 0; b_done = 0; b_tail = 0; cyc = 0;
        while ((b_done < 3) && (cyc < 300)) begin
            @(negedge clk);
            b_in_valid = (b_in < 27);
            b_in_pixel = pix3(b_in);
            #1;
            if (b_frame_done) begin
                b_done++;
                checkn("b_frame_results", b_out, 9 * b_done);
                checkn("b_flush_emits", b_tail, 4);
                b_tail = 0;
            end
            if (b_out_valid && b_out_ready) begin
                check1($sformatf("b_res_%0d", b_out), b_out_result, b_out == 22);
                if ((b_out % 9) >= 5) begin
                    check1("b_flush_ready", b_in_ready, 1'b0);
                    if (!b_in_ready) b_tail++;
                end
                b_out++;
            end
            if (b_in_valid && b_in_ready) b_in++;
            cyc++;
        end
        b_in_valid = 1'b0;
        checkn("b_frames", b_done, 3);
        checkn("b_total_results", b_out, 27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
